// File: rtl/pcpi_result_serializer_pkg.sv
// pcpi_result_serializer_pkg: state encodings and default sizes shared by the result serializer and the instruction loader.
package pcpi_result_serializer_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_NIB_W  = 4;
    localparam int NIBBLES    = DEF_DATA_W / DEF_NIB_W;
    localparam int IDX_W      = $clog2(NIBBLES);
    typedef enum logic [1:0] {IDLE = 2'b00, PRESENT = 2'b01, WAIT_LOW = 2'b10} state_e;
endpackage

// File: rtl/pcpi_result_serializer_if.sv
// pcpi_result_serializer_if: PCPI result inputs plus the nibble-serial host pins.
interface pcpi_result_serializer_if #(parameter int DATA_W = 32, parameter int NIB_W = 4);
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic [DATA_W-1:0] pcpi_rd;
    logic              out_ack;
    logic [NIB_W-1:0]  out_nib;
    logic              out_valid;
    logic              out_last;
    modport slave (input pcpi_ready, pcpi_wr, pcpi_rd, out_ack, output out_nib, out_valid, out_last);
    modport master (output pcpi_ready, pcpi_wr, pcpi_rd, out_ack, input out_nib, out_valid, out_last);
endinterface

// File: rtl/pcpi_result_serializer_sync_ff_chain.sv
// sync_ff_chain: STAGES-deep flop synchronizer for an asynchronous single-bit input, cleared by reset.
module sync_ff_chain #(parameter int STAGES = 2) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain_q, chain_d;
    always_comb chain_d = {chain_q[STAGES-2:0], d};
    always_ff @(posedge clk) chain_q <= rst_n ? chain_d : '0;
    assign q = chain_q[STAGES-1];
endmodule

// File: rtl/pcpi_result_serializer.sv
// pcpi_result_serializer: captures a PCPI writeback result and returns it LSB nibble first over a 4-phase valid/ack pin handshake.
module pcpi_result_serializer
    import pcpi_result_serializer_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NIB_W    = DEF_NIB_W,
    parameter int ACK_SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    pcpi_result_serializer_if.slave bus,
    input  logic clear_err,
    output logic busy,
    output logic drop_err
);
    localparam int N  = DATA_W / NIB_W;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              drop_err_q, drop_err_d;
    logic              ack_s, cap, load;

    sync_ff_chain #(.STAGES(ACK_SYNC)) u_ack_sync (.clk(clk), .rst_n(rst_n), .d(bus.out_ack), .q(ack_s));

    assign cap  = bus.pcpi_ready & bus.pcpi_wr;
    // A new result is accepted only from IDLE or at the instant the final nibble's ack drops.
    assign load = cap && (state_q == IDLE || (state_q == WAIT_LOW && !ack_s && idx_q == LAST));

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        data_d     = data_q;
        drop_err_d = (drop_err_q & ~clear_err) | (cap & ~load);
        case (state_q)
            PRESENT:  state_d = ack_s ? WAIT_LOW : PRESENT;
            WAIT_LOW: if (!ack_s) begin
                state_d = (idx_q == LAST) ? IDLE : PRESENT;
                if (idx_q != LAST) begin
                    idx_d  = idx_q + 1'b1;
                    data_d = data_q >> NIB_W;
                end
            end
            default:  state_d = IDLE;
        endcase
        if (load) begin
            state_d = PRESENT;
            idx_d   = '0;
            data_d  = bus.pcpi_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            data_q     <= '0;
            drop_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            drop_err_q <= drop_err_d;
        end
    end

    assign bus.out_nib   = data_q[NIB_W-1:0];
    assign bus.out_valid = state_q == PRESENT;
    assign bus.out_last  = bus.out_valid && idx_q == LAST;
    assign busy          = state_q != IDLE;
    assign drop_err      = drop_err_q;
endmodule

// File: tb/tb_pcpi_result_serializer.sv
// tb_pcpi_result_serializer: directed scenario tasks with hand-computed nibble streams for the result serializer.
module tb_pcpi_result_serializer;
    logic clk = 1'b0;
    logic rst_n;
    logic clear_err;
    logic busy;
    logic drop_err;
    int   tests = 0;
    int   fails = 0;

    pcpi_result_serializer_if bus ();

    pcpi_result_serializer dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .clear_err(clear_err),
        .busy(busy),
        .drop_err(drop_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic cap_result(input logic [31:0] v);
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b1;
        bus.pcpi_rd    = v;
        tick();
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
    endtask

    // Host side of one nibble: wait for valid, sample, ack high until valid drops, ack low.
    task automatic host_read(output logic [3:0] nib, output logic last, output bit ok);
        int n;
        ok = 1'b1;
        nib = 'x;
        last = 'x;
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        if (!bus.out_valid) begin ok = 1'b0; return; end
        nib  = bus.out_nib;
        last = bus.out_last;
        bus.out_ack = 1'b1;
        n = 0;
        while (bus.out_valid && n < 50) begin tick(); n++; end
        if (bus.out_valid) ok = 1'b0;
        bus.out_ack = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick();
        tests++;
        if ({busy, bus.out_valid, bus.out_last, drop_err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags: busy/valid/last/drop=%b want 0000", {busy, bus.out_valid, bus.out_last, drop_err});
        end
        tests++;
        if (bus.out_nib !== 4'h0) begin
            fails++;
            $display("FAIL reset_nib: got %h want 0", bus.out_nib);
        end
    endtask

    task automatic test_stream;
        logic [31:0] v;
        logic [3:0] nib;
        logic last;
        bit ok;
        v = 32'h89AB_CDEF;
        cap_result(v);
        tests++;
        if ({busy, bus.out_valid} !== 2'b11) begin
            fails++;
            $display("FAIL stream_start: busy/valid=%b want 11", {busy, bus.out_valid});
        end
        for (int i = 0; i < 8; i++) begin
            host_read(nib, last, ok);
            tests++;
            if (!ok || nib !== v[4*i +: 4] || last !== (i == 7)) begin
                fails++;
                $display("FAIL stream_nib%0d: ok=%0d nib=%h last=%b want nib=%h last=%b", i, ok, nib, last, v[4*i +: 4], i == 7);
            end
        end
        tick(2);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL stream_busy_hold: busy=%b want 1", busy);
        end
        tick();
        tests++;
        if ({busy, bus.out_valid, drop_err} !== 3'b000) begin
            fails++;
            $display("FAIL stream_end: busy/valid/drop=%b want 000", {busy, bus.out_valid, drop_err});
        end
    endtask

    task automatic test_latency;
        logic [31:0] v;
        logic [3:0] nib;
        logic last;
        bit ok;
        logic [2:0] seen;
        v = 32'h7654_3210;
        cap_result(v);
        bus.out_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin tick(); seen[k] = bus.out_valid; end
        tests++;
        if (seen !== 3'b011) begin
            fails++;
            $display("FAIL latency_ack_high: valid at N+3,N+2,N+1=%b want 011", seen);
        end
        bus.out_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin tick(); seen[k] = bus.out_valid; end
        tests++;
        if (seen !== 3'b100 || bus.out_nib !== 4'h1) begin
            fails++;
            $display("FAIL latency_ack_low: valid at M+3,M+2,M+1=%b nib=%h want 100 nib=1", seen, bus.out_nib);
        end
        for (int i = 1; i < 8; i++) begin
            host_read(nib, last, ok);
            tests++;
            if (!ok || nib !== v[4*i +: 4]) begin
                fails++;
                $display("FAIL latency_nib%0d: ok=%0d nib=%h want %h", i, ok, nib, v[4*i +: 4]);
            end
        end
        tick(3);
    endtask

    task automatic test_ignore_no_wr;
        bus.pcpi_ready = 1'b1;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = 32'hFFFF_FFFF;
        tick();
        bus.pcpi_ready = 1'b0;
        tick(2);
        tests++;
        if ({busy, bus.out_valid, drop_err} !== 3'b000) begin
            fails++;
            $display("FAIL ignore_no_wr: busy/valid/drop=%b want 000", {busy, bus.out_valid, drop_err});
        end
    endtask

    task automatic test_drop;
        logic [31:0] v;
        logic [3:0] nib;
        logic last;
        bit ok;
        int n;
        v = 32'hCAFE_F00D;
        cap_result(v);
        for (int i = 0; i < 3; i++) begin
            host_read(nib, last, ok);
            tests++;
            if (!ok || nib !== v[4*i +: 4]) begin
                fails++;
                $display("FAIL drop_pre_nib%0d: ok=%0d nib=%h want %h", i, ok, nib, v[4*i +: 4]);
            end
        end
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        cap_result(32'h1234_5678);
        tests++;
        if ({drop_err, bus.out_valid, bus.out_nib} !== {2'b11, 4'hF}) begin
            fails++;
            $display("FAIL drop_set: drop/valid=%b nib=%h want 11 nib=f", {drop_err, bus.out_valid}, bus.out_nib);
        end
        for (int i = 3; i < 8; i++) begin
            host_read(nib, last, ok);
            tests++;
            if (!ok || nib !== v[4*i +: 4] || last !== (i == 7)) begin
                fails++;
                $display("FAIL drop_post_nib%0d: ok=%0d nib=%h last=%b want %h", i, ok, nib, last, v[4*i +: 4]);
            end
        end
        tick(6);
        tests++;
        if ({busy, bus.out_valid, drop_err} !== 3'b001) begin
            fails++;
            $display("FAIL drop_discarded: busy/valid/drop=%b want 001", {busy, bus.out_valid, drop_err});
        end
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        tests++;
        if (drop_err !== 1'b0) begin
            fails++;
            $display("FAIL drop_clear: drop=%b want 0", drop_err);
        end
        cap_result(32'hA5A5_A5A5);
        clear_err = 1'b1;
        cap_result(32'h1234_5678);
        clear_err = 1'b0;
        tests++;
        if ({drop_err, bus.out_valid, bus.out_nib} !== {2'b11, 4'h5}) begin
            fails++;
            $display("FAIL drop_set_wins: drop/valid=%b nib=%h want 11 nib=5", {drop_err, bus.out_valid}, bus.out_nib);
        end
        for (int i = 0; i < 8; i++) host_read(nib, last, ok);
        tick(3);
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [31:0] v;
        logic [31:0] w;
        logic [3:0] nib;
        logic last;
        bit ok;
        int n;
        v = 32'h1111_1111;
        w = 32'h0000_FFFF;
        cap_result(v);
        for (int i = 0; i < 7; i++) host_read(nib, last, ok);
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        tests++;
        if ({bus.out_nib, bus.out_last} !== {4'h1, 1'b1}) begin
            fails++;
            $display("FAIL b2b_final: nib=%h last=%b want 1 1", bus.out_nib, bus.out_last);
        end
        bus.out_ack = 1'b1;
        n = 0;
        while (bus.out_valid && n < 50) begin tick(); n++; end
        bus.out_ack = 1'b0;
        tick(2);
        cap_result(w);
        tests++;
        if ({busy, bus.out_valid, drop_err, bus.out_last, bus.out_nib} !== {4'b1100, 4'hF}) begin
            fails++;
            $display("FAIL b2b_handoff: busy/valid/drop/last=%b nib=%h want 1100 nib=f",
                     {busy, bus.out_valid, drop_err, bus.out_last}, bus.out_nib);
        end
        for (int i = 0; i < 8; i++) begin
            host_read(nib, last, ok);
            tests++;
            if (!ok || nib !== w[4*i +: 4] || last !== (i == 7)) begin
                fails++;
                $display("FAIL b2b_nib%0d: ok=%0d nib=%h last=%b want %h", i, ok, nib, last, w[4*i +: 4]);
            end
        end
        tick(3);
        tests++;
        if ({busy, drop_err} !== 2'b00) begin
            fails++;
            $display("FAIL b2b_end: busy/drop=%b want 00", {busy, drop_err});
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] v;
        logic [3:0] nib;
        logic last;
        bit ok;
        int n;
        cap_result(32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) host_read(nib, last, ok);
        n = 0;
        while (!bus.out_valid && n < 50) begin tick(); n++; end
        bus.out_ack = 1'b1;
        n = 0;
        while (bus.out_valid && n < 50) begin tick(); n++; end
        tests++;
        if ({busy, bus.out_valid} !== 2'b10) begin
            fails++;
            $display("FAIL rstmid_wait_low: busy/valid=%b want 10", {busy, bus.out_valid});
        end
        rst_n = 1'b0;
        tick();
        tests++;
        if ({busy, bus.out_valid, bus.out_nib} !== {2'b00, 4'h0}) begin
            fails++;
            $display("FAIL rstmid_abort: busy/valid=%b nib=%h want 00 nib=0", {busy, bus.out_valid}, bus.out_nib);
        end
        rst_n = 1'b1;
        bus.out_ack = 1'b0;
        tick(5);
        tests++;
        if ({busy, bus.out_valid} !== 2'b00) begin
            fails++;
            $display("FAIL rstmid_quiet: busy/valid=%b want 00", {busy, bus.out_valid});
        end
        v = 32'h7654_3210;
        cap_result(v);
        for (int i = 0; i < 8; i++) begin
            host_read(nib, last, ok);
            tests++;
            if (!ok || nib !== v[4*i +: 4] || last !== (i == 7)) begin
                fails++;
                $display("FAIL rstmid_nib%0d: ok=%0d nib=%h last=%b want %h", i, ok, nib, last, v[4*i +: 4]);
            end
        end
        tick(3);
    endtask

    initial begin
        rst_n          = 1'b0;
        clear_err      = 1'b0;
        bus.pcpi_ready = 1'b0;
        bus.pcpi_wr    = 1'b0;
        bus.pcpi_rd    = '0;
        bus.out_ack    = 1'b0;
        test_reset();
        test_stream();
        test_latency();
        test_ignore_no_wr();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pcpi_result_serializer.md
Name: pcpi_result_serializer

Overview:
- Downstream stage of the PCPI coprocessor in the tt_um top level.
- Captures the 32-bit result (pcpi_rd) when the coprocessor completes with a register write.
- Returns the result to the off-chip host as 8 nibbles over the narrow pin interface, using a 4-phase valid/ack handshake.
- Mirrors the upstream nibble-serial instruction loader, so the host reads results the same way it writes instructions.

Parameters:
- DATA_W, 32, result width; must be a multiple of NIB_W.
- NIB_W, 4, nibble width presented on pins.
- ACK_SYNC, 2, synchronizer stages on out_ack; minimum 2.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- pcpi_ready  in  1  coprocessor completion strobe, one cycle
- pcpi_wr  in  1  result valid for writeback; qualifies pcpi_ready
- pcpi_rd  in  DATA_W  result data
- out_ack  in  1  host acknowledge from pin, asynchronous
- clear_err  in  1  clears drop_err
- out_nib  out  NIB_W  current nibble
- out_valid  out  1  nibble presented
- out_last  out  1  current nibble is the final one (index NIBBLES-1)
- busy  out  1  transfer in progress (state != IDLE)
- drop_err  out  1  sticky: a result arrived while busy and was discarded

Behaviour:
Reset and derived signals
- Reset: rst_n low at a clk edge clears state to IDLE, index to 0, shift register to 0, sync chain to 0, and all outputs to 0.
- Reset mid-transfer aborts the transfer with no further nibbles.
- cap = pcpi_ready & pcpi_wr.
- pcpi_ready without pcpi_wr is ignored and never sets drop_err.
- ack_s is out_ack after ACK_SYNC flops. All handshake decisions use ack_s only.
- NIBBLES = DATA_W/NIB_W. Nibbles go out LSB first: index i carries pcpi_rd[NIB_W*i +: NIB_W].

State machine
- IDLE:
  - On cap: latch pcpi_rd, set index 0, go to PRESENT.
  - out_valid is 1 in the cycle after cap.
  - ack_s is ignored in IDLE.
- PRESENT:
  - out_valid=1; out_nib is stable for the whole state.
  - When ack_s=1: out_valid<=0, go to WAIT_LOW.
- WAIT_LOW:
  - out_valid=0, and out_nib holds its value.
  - When ack_s=0 and index<NIBBLES-1: index++, go to PRESENT; the next nibble and out_valid=1 appear together.
  - When ack_s=0 and index=NIBBLES-1 and no cap: go to IDLE; busy drops in the same cycle out_valid would have risen.
  - When ack_s=0 and index=NIBBLES-1 and cap in the same cycle: accept the new result directly (index 0, PRESENT). No drop.

Timing and flags
- Latency: an out_ack pin change is reflected in out_valid ACK_SYNC+1 cycles later.
- out_last = out_valid & (index==NIBBLES-1).
- cap while busy, other than the final WAIT_LOW handoff above: the result is discarded, drop_err<=1, and the current transfer is unaffected.
- drop_err set and clear_err in the same cycle: set wins.
- An ack held high indefinitely stalls in WAIT_LOW. There is no timeout.
- Data path: shift register or indexed mux; either is acceptable provided out_nib is registered and glitch-free.

Decomposition:
- Shared package holds:
  - state encodings IDLE=2'b00, PRESENT=2'b01, WAIT_LOW=2'b10;
  - NIBBLES;
  - index width $clog2(NIBBLES).
- This package is shared with the upstream instruction loader.
- One sub-module, sync_ff_chain (parameter STAGES, reset to 0), for out_ack. It is reused by the loader for its strobe input.

Test Plan:
- Reset, then cap with pcpi_rd=0x89ABCDEF, host acks each nibble -> out_nib sequence F,E,D,C,B,A,9,8; out_last only on 8; busy=0 after the final ack-low; drop_err=0.
- Ack latency: with ACK_SYNC=2, raise out_ack at cycle N -> out_valid falls at N+3; lower ack at M -> next nibble valid at M+3.
- pcpi_ready=1, pcpi_wr=0 in IDLE -> no transfer, busy=0, drop_err=0.
- Cap 0x12345678 during nibble index 3 of the transfer 0xCAFEF00D -> the 0xCAFEF00D stream completes intact, drop_err=1, and 0x12345678 is never output; assert clear_err together with a second drop -> drop_err stays 1.
- Back-to-back: cap 0x0000FFFF in the same cycle the final ack_s goes low for 0x11111111 -> no drop, next valid nibble is F, followed by F,F,F,0,0,0,0.
- Assert rst_n low while in WAIT_LOW at index 5 -> next cycle out_valid=0, busy=0, out_nib=0; a new cap then restarts at index 0.
